// File: rtl/dcache_responder_if.sv
// Purpose: Mem-stage request bus and backing-memory port of the data cache.
// Ports (signals):
//   dc_*        request from the Mem stage and its completion (dc_ack, dc_data_from_cache)
//   store_type  store size: 00 byte, 01 half, 10 word, 11 double
//   mem_*       backing-memory request (single-beat write or 8-beat line read)
// Modports: slave = cache side, master = Mem stage plus memory side.
interface dcache_responder_if;
  localparam int unsigned LINE_W = 58;
  localparam int unsigned DATA_W = 64;

  logic              dc_req;
  logic [LINE_W-1:0] dc_line_addr;
  logic [2:0]        dc_word_select;
  logic [2:0]        dc_byte_offset;
  logic [DATA_W-1:0] dc_data_to_cache;
  logic              dc_read_write_n;
  logic [1:0]        store_type;
  logic              dc_ack;
  logic [DATA_W-1:0] dc_data_from_cache;

  logic              mem_req;
  logic              mem_we;
  logic [LINE_W-1:0] mem_line_addr;
  logic [2:0]        mem_word;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  dc_req, dc_line_addr, dc_word_select, dc_byte_offset, dc_data_to_cache,
           dc_read_write_n, store_type, mem_ack, mem_rvalid, mem_rdata,
    output dc_ack, dc_data_from_cache, mem_req, mem_we, mem_line_addr, mem_word,
           mem_wdata, mem_wmask
  );

  modport master (
    output dc_req, dc_line_addr, dc_word_select, dc_byte_offset, dc_data_to_cache,
           dc_read_write_n, store_type, mem_ack, mem_rvalid, mem_rdata,
    input  dc_ack, dc_data_from_cache, mem_req, mem_we, mem_line_addr, mem_word,
           mem_wdata, mem_wmask
  );
endinterface

// File: rtl/dcache_responder.sv
// Purpose: direct-mapped, write-through, no-write-allocate data cache servicing the
//          Mem stage. 64-byte lines of 8 big-endian 64-bit words; read misses are
//          filled with an 8-beat burst, stores go to memory as one masked beat.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   bus         dcache_responder_if.slave (Mem-stage request + backing-memory port)
module dcache_responder #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  dcache_responder_if.slave  bus
);
  localparam int unsigned LINE_W    = 58;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned WSEL_W    = 3;
  localparam int unsigned NUM_LINES = 1 << IDX_W;
  localparam int unsigned ADDR_W    = IDX_W + WSEL_W;
  localparam int unsigned NUM_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_TAG, S_FILL, S_WRITE, S_ACK} state_t;

  typedef struct packed {
    logic [LINE_W-1:0] line_addr;
    logic [WSEL_W-1:0] word;
    logic [2:0]        offset;
    logic [DATA_W-1:0] data;
    logic              rw_n;
    logic [1:0]        stype;
  } req_t;

  state_t state_q, state_n;
  req_t   req_q, req_n;
  logic [WSEL_W-1:0] beat_q, beat_n;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [DATA_W-1:0]    data_arr [NUM_WORDS];

  logic              dc_ack_q, dc_ack_n;
  logic [DATA_W-1:0] dc_data_q, dc_data_n;
  logic              mem_req_q, mem_req_n;
  logic              mem_we_q, mem_we_n;
  logic [LINE_W-1:0] mem_addr_q, mem_addr_n;
  logic [WSEL_W-1:0] mem_word_q, mem_word_n;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
  logic [7:0]        mem_wmask_q, mem_wmask_n;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic              fill_done;

  // Lookup against the captured request
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic              hit;
  logic [DATA_W-1:0] line_word;

  assign cur_idx   = req_q.line_addr[IDX_W-1:0];
  assign cur_tag   = req_q.line_addr[IDX_W+TAG_W-1:IDX_W];
  assign hit       = valid_q[cur_idx] && (tag_arr[cur_idx] == cur_tag);
  assign line_word = data_arr[{cur_idx, req_q.word}];

  // Store lane alignment: offset 0 is the MSB byte, misaligned offsets are rounded down
  logic [7:0]        st_mask;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] byte_en;
  logic [DATA_W-1:0] merged;
  logic [2:0]        aligned;

  always_comb begin
    st_mask = '0;
    st_data = '0;
    aligned = '0;
    case (req_q.stype)
      2'b00: begin
        aligned = req_q.offset;
        st_mask = 8'h80 >> aligned;
        st_data = {56'b0, req_q.data[7:0]} << {3'(3'd7 - aligned), 3'b000};
      end
      2'b01: begin
        aligned = {req_q.offset[2:1], 1'b0};
        st_mask = 8'hC0 >> aligned;
        st_data = {48'b0, req_q.data[15:0]} << {3'(3'd6 - aligned), 3'b000};
      end
      2'b10: begin
        aligned = {req_q.offset[2], 2'b00};
        st_mask = 8'hF0 >> aligned;
        st_data = {32'b0, req_q.data[31:0]} << {3'(3'd4 - aligned), 3'b000};
      end
      default: begin
        st_mask = 8'hFF;
        st_data = req_q.data;
      end
    endcase
  end

  always_comb begin
    byte_en = '0;
    for (int i = 0; i < 8; i++) begin
      byte_en[i*8 +: 8] = {8{st_mask[i]}};
    end
    merged = (line_word & ~byte_en) | (st_data & byte_en);
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state_q;
    req_n       = req_q;
    beat_n      = beat_q;
    dc_ack_n    = 1'b0;
    dc_data_n   = dc_data_q;
    mem_req_n   = mem_req_q;
    mem_we_n    = mem_we_q;
    mem_addr_n  = mem_addr_q;
    mem_word_n  = mem_word_q;
    mem_wdata_n = mem_wdata_q;
    mem_wmask_n = mem_wmask_q;
    arr_we      = 1'b0;
    arr_addr    = {cur_idx, req_q.word};
    arr_wdata   = merged;
    fill_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.dc_req) begin
          req_n.line_addr = bus.dc_line_addr;
          req_n.word      = bus.dc_word_select;
          req_n.offset    = bus.dc_byte_offset;
          req_n.data      = bus.dc_data_to_cache;
          req_n.rw_n      = bus.dc_read_write_n;
          req_n.stype     = bus.store_type;
          state_n         = S_TAG;
        end
      end
      S_TAG: begin
        if (req_q.rw_n) begin
          if (hit) begin
            dc_data_n = line_word;
            dc_ack_n  = 1'b1;
            state_n   = S_ACK;
          end else begin
            mem_req_n  = 1'b1;
            mem_we_n   = 1'b0;
            mem_addr_n = req_q.line_addr;
            beat_n     = '0;
            state_n    = S_FILL;
          end
        end else begin
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b1;
          mem_addr_n  = req_q.line_addr;
          mem_word_n  = req_q.word;
          mem_wdata_n = st_data;
          mem_wmask_n = st_mask;
          if (hit) begin
            arr_we    = 1'b1;
            dc_data_n = merged;
          end
          state_n = S_WRITE;
        end
      end
      S_FILL: begin
        if (bus.mem_ack) begin
          mem_req_n = 1'b0;
        end
        if (bus.mem_rvalid) begin
          arr_we    = 1'b1;
          arr_addr  = {cur_idx, beat_q};
          arr_wdata = bus.mem_rdata;
          beat_n    = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            // Earlier beats are already in the array; the last one is bypassed
            fill_done = 1'b1;
            dc_data_n = (req_q.word == 3'd7) ? bus.mem_rdata : line_word;
            dc_ack_n  = 1'b1;
            state_n   = S_ACK;
          end
        end
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          mem_req_n = 1'b0;
          dc_ack_n  = 1'b1;
          state_n   = S_ACK;
        end
      end
      S_ACK: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, request capture, valid bits and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      beat_q      <= '0;
      valid_q     <= '0;
      dc_ack_q    <= 1'b0;
      dc_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_word_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      state_q     <= state_n;
      req_q       <= req_n;
      beat_q      <= beat_n;
      dc_ack_q    <= dc_ack_n;
      dc_data_q   <= dc_data_n;
      mem_req_q   <= mem_req_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_word_q  <= mem_word_n;
      mem_wdata_q <= mem_wdata_n;
      mem_wmask_q <= mem_wmask_n;
      if (fill_done) begin
        valid_q[cur_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate them
  always_ff @(posedge clk) begin
    if (!reset && arr_we) begin
      data_arr[arr_addr] <= arr_wdata;
    end
    if (!reset && fill_done) begin
      tag_arr[cur_idx] <= cur_tag;
    end
  end

  assign bus.dc_ack             = dc_ack_q;
  assign bus.dc_data_from_cache = dc_data_q;
  assign bus.mem_req            = mem_req_q;
  assign bus.mem_we             = mem_we_q;
  assign bus.mem_line_addr      = mem_addr_q;
  assign bus.mem_word           = mem_word_q;
  assign bus.mem_wdata          = mem_wdata_q;
  assign bus.mem_wmask          = mem_wmask_q;
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
Data-cache responder that services the Mem stage's dc_req/dc_ack request interface.
- Direct-mapped, 64-byte lines of 8 big-endian 64-bit words, write-through, no-write-allocate.
- Sits between the Mem pipeline stage and the backing memory port.
- Read misses are filled by an 8-beat burst; stores are merged into the line on a hit and always written through to memory as a single masked beat.

Parameters:
IDX_W, 6, index bits; NUM_LINES = 2**IDX_W
TAG_W, 8, tag bits taken from dc_line_addr[IDX_W+TAG_W-1:IDX_W]; higher line-address bits ignored

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
dc_req  in  1  request from Mem stage, held until dc_ack
dc_line_addr  in  58  line address (byte address >> 6)
dc_word_select  in  3  word within line
dc_byte_offset  in  3  byte within word (0 = MSB byte, bits [63:56])
dc_data_to_cache  in  64  store data, right-justified
dc_read_write_n  in  1  1 = load, 0 = store
store_type  in  2  00 byte, 01 half, 10 word, 11 double
dc_ack  out  1  one-cycle completion pulse
dc_data_from_cache  out  64  full requested word, valid with dc_ack
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = single-beat write, 0 = 8-beat line read
mem_line_addr  out  58  line address
mem_word  out  3  word index for writes
mem_wdata  out  64  write data, byte-lane aligned
mem_wmask  out  8  byte enables; bit 7 = bits [63:56]
mem_ack  in  1  one-cycle accept pulse
mem_rvalid  in  1  read beat valid
mem_rdata  in  64  read beat data, words 0..7 in order

Behaviour:
- Reset (sync): all valid bits cleared, state IDLE, beat counter 0.
  - Outputs on reset: dc_ack=0, dc_data_from_cache=0, mem_req=0, mem_we=0, mem_line_addr=0, mem_word=0, mem_wdata=0, mem_wmask=0.
  - Reset mid-fill or mid-write abandons the operation; line is not validated; late mem_rvalid beats are ignored.
- One outstanding request at a time. All outputs are registered.
- States:
  - IDLE: on dc_req=1, capture every request field into registers -> TAG. dc_req is ignored in all other states.
  - TAG: index/tag compare against the captured request.
    - Load hit -> ACK; data = line[word].
    - Load miss -> FILL; mem_req=1, mem_we=0.
    - Store -> WRITE; on a hit, the merged bytes are written into the line in this cycle; a miss does not allocate.
  - FILL: hold mem_req until mem_ack (mem_req drops the cycle after mem_ack).
    - Each mem_rvalid writes the beat to line[beat] and increments a 3-bit counter.
    - mem_rvalid may occur no earlier than the cycle after mem_ack; gaps between beats are allowed.
    - On beat 7: set valid, write tag, capture word[dc_word_select] (bypass) -> ACK.
  - WRITE: mem_req=1, mem_we=1, mem_word=captured word, mem_wdata/mem_wmask = lane-aligned store. Hold until mem_ack -> ACK.
  - ACK: dc_ack=1 for exactly one cycle, with dc_data_from_cache valid -> IDLE.
    - dc_data_from_cache holds its last value outside ACK.
    - For stores it returns the post-merge word on a hit, otherwise unchanged.
- Latency: load hit = dc_ack two cycles after dc_req is first sampled in IDLE. Back-to-back requests: a new dc_req is sampled in the cycle after ACK.
- Store lane rules (big-endian, offset o):
  - byte: data[7:0] -> lane o.
  - half: o forced to o & 6; data[15:0] -> lanes o, o+1.
  - word: o forced to o & 4; data[31:0] -> lanes o..o+3.
  - double: o ignored; all 8 lanes.
  - Misaligned offsets are silently aligned; no trap.
- Loads always return the full 64-bit word; byte/half extraction and sign extension happen downstream.
- Tag compare uses TAG_W bits only; aliasing above those bits is by design.

Test Plan:
- Cold load, addr 0x1040 (line 0x41, word 0): FILL issues mem_line_addr=0x41, mem_we=0; memory returns words 0x10..0x17 -> dc_ack one cycle after beat 7, dc_data_from_cache=0x10. Repeat load of word 5 -> hit, ack 2 cycles after req, data 0x15, no mem_req.
- STB, offset 3, data 0xAB to the cached line, word 2 -> mem_wmask=0x10, mem_wdata[39:32]=0xAB; after mem_ack, dc_ack. Reload word 2 -> byte lane 3 = 0xAB, other bytes unchanged.
- Store to uncached line 0x80 -> write-through only; a following load of line 0x80 misses and performs an 8-beat FILL.
- Conflict: load line 0x41, then line 0x41 + 2^IDX_W -> second load misses, refills; reload of 0x41 misses again.
- Fill with gaps (rvalid every 3rd cycle), then reset asserted after beat 4 -> mem_req=0, dc_ack never pulses, later beats ignored; next load of the same line misses.
- STD data 0x0123456789ABCDEF, offset 5 -> mem_wmask=0xFF, mem_wdata=0x0123456789ABCDEF; STH offset 3 data 0xBEEF -> offset aligned to 2, mem_wmask=0x30, mem_wdata[47:32]=0xBEEF.
